// File: rtl/sp_dram_port.sv
// rtl/sp_dram_port.sv - narrow-word front end with a 128-bit write-combining line buffer for sp_dram
module sp_dram_port #(
    parameter int WIDTH    = 32,
    parameter int SEL_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [25+SEL_BITS:0]  addr,
    input  logic [WIDTH-1:0]      din,
    input  logic                  we,
    input  logic                  re,
    input  logic                  flush,
    output logic                  ready,
    output logic [WIDTH-1:0]      dout,
    output logic                  valid,
    output logic                  idle,
    output logic [25:0]           mem_addr,
    output logic [127:0]          mem_din,
    input  logic [127:0]          mem_dout,
    output logic [15:0]           mem_mask,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic                  mem_ready
);

    localparam int MB = WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WB, RD_ISSUE, RD_WAIT} state_t;

    state_t               state_q, state_d;
    logic                 dirty_q, dirty_d;
    logic [15:0]          line_mask_q, line_mask_d;
    logic [25:0]          line_addr_q, line_addr_d;
    logic [127:0]         line_data_q, line_data_d;
    logic                 pend_we_q, pend_we_d;
    logic                 pend_re_q, pend_re_d;
    logic [25+SEL_BITS:0] pend_addr_q, pend_addr_d;
    logic [WIDTH-1:0]     pend_din_q, pend_din_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic                 valid_q, valid_d;

    // The merge path is shared: a fresh write in IDLE, or a deferred write into the just-cleaned buffer in WB.
    logic [25+SEL_BITS:0] wr_addr;
    logic [WIDTH-1:0]     wr_din;
    logic [127:0]         merged_data;
    logic [15:0]          merged_mask;
    logic [MB-1:0]        lane_ones;

    always_comb begin
        lane_ones   = '1;
        wr_addr     = (state_q == WB) ? pend_addr_q : addr;
        wr_din      = (state_q == WB) ? pend_din_q  : din;
        merged_data = line_data_q;
        merged_data[int'(wr_addr[SEL_BITS-1:0]) * WIDTH +: WIDTH] = wr_din;
        merged_mask = ((state_q == WB) ? 16'h0000 : line_mask_q)
                      | (16'(lane_ones) << (int'(wr_addr[SEL_BITS-1:0]) * MB));
    end

    always_comb begin
        state_d     = state_q;
        dirty_d     = dirty_q;
        line_mask_d = line_mask_q;
        line_addr_d = line_addr_q;
        line_data_d = line_data_q;
        pend_we_d   = pend_we_q;
        pend_re_d   = pend_re_q;
        pend_addr_d = pend_addr_q;
        pend_din_d  = pend_din_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_mask    = 16'h0000;
        mem_addr    = line_addr_q;

        unique case (state_q)
            IDLE: begin
                if (we) begin
                    if (!dirty_q || addr[25+SEL_BITS:SEL_BITS] == line_addr_q) begin
                        line_data_d = merged_data;
                        line_mask_d = merged_mask;
                        line_addr_d = addr[25+SEL_BITS:SEL_BITS];
                        dirty_d     = 1'b1;
                        if (merged_mask == 16'hFFFF) state_d = WB;
                    end else begin
                        pend_we_d   = 1'b1;
                        pend_addr_d = addr;
                        pend_din_d  = din;
                        state_d     = WB;
                    end
                end else if (re) begin
                    // Drain a dirty line first, even an unrelated one, so reads never overtake writes.
                    pend_re_d   = 1'b1;
                    pend_addr_d = addr;
                    state_d     = dirty_q ? WB : RD_ISSUE;
                end else if (flush && dirty_q) begin
                    state_d = WB;
                end
            end
            WB: begin
                mem_we   = mem_ready;
                mem_mask = line_mask_q;
                if (mem_ready) begin
                    dirty_d     = 1'b0;
                    line_mask_d = 16'h0000;
                    if (pend_we_q) begin
                        line_data_d = merged_data;
                        line_mask_d = merged_mask;
                        line_addr_d = pend_addr_q[25+SEL_BITS:SEL_BITS];
                        dirty_d     = 1'b1;
                        pend_we_d   = 1'b0;
                        state_d     = IDLE;
                    end else if (pend_re_q) begin
                        state_d = RD_ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RD_ISSUE: begin
                mem_re   = mem_ready;
                mem_addr = pend_addr_q[25+SEL_BITS:SEL_BITS];
                if (mem_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                mem_addr = pend_addr_q[25+SEL_BITS:SEL_BITS];
                if (mem_ready) begin
                    dout_d    = mem_dout[int'(pend_addr_q[SEL_BITS-1:0]) * WIDTH +: WIDTH];
                    valid_d   = 1'b1;
                    pend_re_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dirty_q     <= 1'b0;
            line_mask_q <= '0;
            line_addr_q <= '0;
            line_data_q <= '0;
            pend_we_q   <= 1'b0;
            pend_re_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_din_q  <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dirty_q     <= dirty_d;
            line_mask_q <= line_mask_d;
            line_addr_q <= line_addr_d;
            line_data_q <= line_data_d;
            pend_we_q   <= pend_we_d;
            pend_re_q   <= pend_re_d;
            pend_addr_q <= pend_addr_d;
            pend_din_q  <= pend_din_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign idle    = (state_q == IDLE) && !dirty_q;
    assign dout    = dout_q;
    assign valid   = valid_q;
    assign mem_din = line_data_q;

endmodule
